// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit types: state encoding, opcodes, mux selects and control word.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 7;

  typedef enum logic [STATE_W-1:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_I    = 4'd3,
    S_WB_ALU  = 4'd4,
    S_EX_ADDR = 4'd5,
    S_MEM_LD  = 4'd6,
    S_WB_LD   = 4'd7,
    S_MEM_ST  = 4'd8,
    S_EX_BR   = 4'd9,
    S_BR_TAKE = 4'd10,
    S_JAL     = 4'd11,
    S_JALR    = 4'd12,
    S_ECALL   = 4'd13,
    S_HALT    = 4'd14
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  localparam logic       SRC_A_PC   = 1'b0;
  localparam logic       SRC_A_REG  = 1'b1;
  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic PC_SRC_ALU    = 1'b0;
  localparam logic PC_SRC_ALUOUT = 1'b1;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_source;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

  // Overlay the sequential PC+4 update onto a control word.
  function automatic ctrl_t with_pc_plus4(input ctrl_t c);
    ctrl_t r;
    r           = c;
    r.alu_src_a = SRC_A_PC;
    r.alu_src_b = SRC_B_FOUR;
    r.alu_op    = ALU_OP_ADD;
    r.pc_source = PC_SRC_ALU;
    r.pc_write  = 1'b1;
    return r;
  endfunction

  function automatic logic is_load(input logic [OPCODE_W-1:0] op);
    return op == OP_LOAD;
  endfunction

endpackage

// File: rtl/control_fsm_outputs.sv
// Combinational decode of the current state (plus handshake inputs) into the control word.
module control_fsm_outputs
  import cpu_ctrl_pkg::*;
(
  input  logic   reset_i,
  input  state_e state_i,
  input  logic   mem_ready_i,
  input  logic   bcond_i,
  input  logic   halt_cond_i,
  output ctrl_t  ctrl_c_o
);

  // Moore outputs per state; Mealy terms only for the handshake/condition inputs.
  always_comb begin
    ctrl_c_o = '0;
    if (reset_i) begin
      case (state_i)
        S_IF: begin
          ctrl_c_o.mem_read = 1'b1;
          ctrl_c_o.ir_write = mem_ready_i;
        end
        S_ID: begin
          ctrl_c_o.alu_src_a = SRC_A_PC;
          ctrl_c_o.alu_src_b = SRC_B_FOUR;
          ctrl_c_o.alu_op    = ALU_OP_ADD;
        end
        S_EX_R: begin
          ctrl_c_o.alu_src_a = SRC_A_REG;
          ctrl_c_o.alu_src_b = SRC_B_REG;
          ctrl_c_o.alu_op    = ALU_OP_FUNCT;
        end
        S_EX_I: begin
          ctrl_c_o.alu_src_a = SRC_A_REG;
          ctrl_c_o.alu_src_b = SRC_B_IMM;
          ctrl_c_o.alu_op    = ALU_OP_FUNCT;
        end
        S_WB_ALU: begin
          ctrl_c_o.reg_write = 1'b1;
          ctrl_c_o           = with_pc_plus4(ctrl_c_o);
        end
        S_EX_ADDR: begin
          ctrl_c_o.alu_src_a = SRC_A_REG;
          ctrl_c_o.alu_src_b = SRC_B_IMM;
          ctrl_c_o.alu_op    = ALU_OP_ADD;
        end
        S_MEM_LD: begin
          ctrl_c_o.mem_read = 1'b1;
          ctrl_c_o.i_or_d   = 1'b1;
        end
        S_WB_LD: begin
          ctrl_c_o.reg_write  = 1'b1;
          ctrl_c_o.mem_to_reg = 1'b1;
          ctrl_c_o            = with_pc_plus4(ctrl_c_o);
        end
        S_MEM_ST: begin
          ctrl_c_o.mem_write = 1'b1;
          ctrl_c_o.i_or_d    = 1'b1;
          if (mem_ready_i) ctrl_c_o = with_pc_plus4(ctrl_c_o);
        end
        S_EX_BR: begin
          ctrl_c_o.alu_src_a = SRC_A_REG;
          ctrl_c_o.alu_src_b = SRC_B_REG;
          ctrl_c_o.alu_op    = ALU_OP_BRANCH;
          if (!bcond_i) begin
            ctrl_c_o.pc_write  = 1'b1;
            ctrl_c_o.pc_source = PC_SRC_ALUOUT;
          end
        end
        S_BR_TAKE: begin
          ctrl_c_o.alu_src_a = SRC_A_PC;
          ctrl_c_o.alu_src_b = SRC_B_IMM;
          ctrl_c_o.alu_op    = ALU_OP_ADD;
          ctrl_c_o.pc_source = PC_SRC_ALU;
          ctrl_c_o.pc_write  = 1'b1;
        end
        S_JAL, S_JALR: begin
          ctrl_c_o.reg_write = 1'b1;
          ctrl_c_o.alu_src_a = (state_i == S_JALR) ? SRC_A_REG : SRC_A_PC;
          ctrl_c_o.alu_src_b = SRC_B_IMM;
          ctrl_c_o.alu_op    = ALU_OP_ADD;
          ctrl_c_o.pc_source = PC_SRC_ALU;
          ctrl_c_o.pc_write  = 1'b1;
        end
        S_ECALL: begin
          if (!halt_cond_i) ctrl_c_o = with_pc_plus4(ctrl_c_o);
        end
        S_HALT: ctrl_c_o.halted = 1'b1;
        default: ctrl_c_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32I control unit: state register, retired-instruction counter, control outputs.
module control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                bcond,
  input  logic                halt_cond,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                pc_source,
  output logic [1:0]          alu_op,
  output logic                halted,
  output logic [CNT_W-1:0]    instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl;
  logic             retire;

  control_fsm_outputs u_outputs (
    .reset_i     (reset),
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .bcond_i     (bcond),
    .halt_cond_i (halt_cond),
    .ctrl_c_o    (ctrl)
  );

  // Next-state sequencing through fetch/decode/execute/memory/writeback.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:      if (mem_ready) state_d = S_ID;
      S_ID: begin
        case (opcode)
          OP_RTYPE:          state_d = S_EX_R;
          OP_ITYPE:          state_d = S_EX_I;
          OP_LOAD, OP_STORE: state_d = S_EX_ADDR;
          OP_BRANCH:         state_d = S_EX_BR;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_SYSTEM:         state_d = S_ECALL;
          default:           state_d = S_HALT;
        endcase
      end
      S_EX_R, S_EX_I: state_d = S_WB_ALU;
      S_EX_ADDR:      state_d = is_load(opcode) ? S_MEM_LD : S_MEM_ST;
      S_MEM_LD:       if (mem_ready) state_d = S_WB_LD;
      S_MEM_ST:       if (mem_ready) state_d = S_IF;
      S_EX_BR:        state_d = bcond ? S_BR_TAKE : S_IF;
      S_ECALL:        state_d = halt_cond ? S_HALT : S_IF;
      S_HALT:         state_d = S_HALT;
      S_WB_ALU, S_WB_LD, S_BR_TAKE, S_JAL, S_JALR: state_d = S_IF;
      default:        state_d = S_IF;
    endcase
  end

  // An instruction retires on its PC write, or when an ECALL stops the CPU.
  always_comb begin
    retire = ctrl.pc_write | ((state_q == S_ECALL) & halt_cond);
    cnt_d  = cnt_q;
    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ir_write    = ctrl.ir_write;
  assign reg_write   = ctrl.reg_write;
  assign mem_read    = ctrl.mem_read;
  assign mem_write   = ctrl.mem_write;
  assign i_or_d      = ctrl.i_or_d;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign pc_source   = ctrl.pc_source;
  assign alu_op      = ctrl.alu_op;
  assign halted      = ctrl.halted;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: CPI table, corner sequences, randomized instruction stream.
module tb_control_fsm;

  // Control word bit weights: {pcw,irw,rw,mr,mw,iod,m2r,a,b[1:0],ps,op[1:0],h}
  localparam logic [13:0] W_PCW  = 14'h2000;
  localparam logic [13:0] W_IRW  = 14'h1000;
  localparam logic [13:0] W_RW   = 14'h0800;
  localparam logic [13:0] W_MR   = 14'h0400;
  localparam logic [13:0] W_MW   = 14'h0200;
  localparam logic [13:0] W_IOD  = 14'h0100;
  localparam logic [13:0] W_M2R  = 14'h0080;
  localparam logic [13:0] W_A    = 14'h0040;
  localparam logic [13:0] W_BIMM = 14'h0020;
  localparam logic [13:0] W_B4   = 14'h0010;
  localparam logic [13:0] W_PS   = 14'h0008;
  localparam logic [13:0] W_OPF  = 14'h0004;
  localparam logic [13:0] W_OPBR = 14'h0002;
  localparam logic [13:0] W_H    = 14'h0001;
  localparam logic [13:0] W_PC4  = W_PCW | W_B4;

  localparam logic [6:0] O_R  = 7'b0110011;
  localparam logic [6:0] O_I  = 7'b0010011;
  localparam logic [6:0] O_LD = 7'b0000011;
  localparam logic [6:0] O_ST = 7'b0100011;
  localparam logic [6:0] O_BR = 7'b1100011;
  localparam logic [6:0] O_JL = 7'b1101111;
  localparam logic [6:0] O_JR = 7'b1100111;
  localparam logic [6:0] O_EC = 7'b1110011;

  logic        clk = 1'b0;
  logic        reset, bcond, halt_cond, mem_ready;
  logic [6:0]  opcode;
  logic        pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d, mem_to_reg;
  logic        alu_src_a, pc_source, halted;
  logic [1:0]  alu_src_b, alu_op;
  logic [31:0] instr_count;
  logic        pc_write_s, ir_write_s, reg_write_s, mem_read_s, mem_write_s, i_or_d_s, mem_to_reg_s;
  logic        alu_src_a_s, pc_source_s, halted_s;
  logic [1:0]  alu_src_b_s, alu_op_s;
  logic [2:0]  instr_count_s;
  logic [13:0] act_w, act_s;

  always #5 clk = ~clk;

  control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_cond(halt_cond),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op),
    .halted(halted), .instr_count(instr_count)
  );

  // Narrow-counter twin so the modulo wrap is reachable in a short run.
  control_fsm #(.CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_cond(halt_cond),
    .mem_ready(mem_ready), .pc_write(pc_write_s), .ir_write(ir_write_s), .reg_write(reg_write_s),
    .mem_read(mem_read_s), .mem_write(mem_write_s), .i_or_d(i_or_d_s), .mem_to_reg(mem_to_reg_s),
    .alu_src_a(alu_src_a_s), .alu_src_b(alu_src_b_s), .pc_source(pc_source_s), .alu_op(alu_op_s),
    .halted(halted_s), .instr_count(instr_count_s)
  );

  assign act_w = {pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d, mem_to_reg,
                  alu_src_a, alu_src_b, pc_source, alu_op, halted};
  assign act_s = {pc_write_s, ir_write_s, reg_write_s, mem_read_s, mem_write_s, i_or_d_s,
                  mem_to_reg_s, alu_src_a_s, alu_src_b_s, pc_source_s, alu_op_s, halted_s};

  typedef struct packed { logic mr; logic [13:0] w; } step_t;
  typedef struct packed {
    logic [6:0] op; logic bc; logic hc; logic [7:0] cyc; logic [7:0] delta;
  } vec_t;

  step_t       trace[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [31:0] model_cnt;
  int          obs_memd, obs_m2r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic step_t mk(input logic mr, input logic [13:0] w);
    step_t s;
    s.mr = mr;
    s.w  = w;
    return s;
  endfunction

  // Reference model: expected per-cycle control words for one instruction.
  task automatic build_trace(input logic [6:0] op, input logic bc, input logic hc,
                             input int fw, input int mw, output logic retires, output logic halts);
    trace.delete();
    retires = 1'b1;
    halts   = 1'b0;
    for (int i = 0; i < fw; i++) trace.push_back(mk(1'b0, W_MR));
    trace.push_back(mk(1'b1, W_MR | W_IRW));
    trace.push_back(mk(rnd(), W_B4));
    case (op)
      O_R: begin
        trace.push_back(mk(rnd(), W_A | W_OPF));
        trace.push_back(mk(rnd(), W_RW | W_PC4));
      end
      O_I: begin
        trace.push_back(mk(rnd(), W_A | W_BIMM | W_OPF));
        trace.push_back(mk(rnd(), W_RW | W_PC4));
      end
      O_LD: begin
        trace.push_back(mk(rnd(), W_A | W_BIMM));
        for (int i = 0; i < mw; i++) trace.push_back(mk(1'b0, W_MR | W_IOD));
        trace.push_back(mk(1'b1, W_MR | W_IOD));
        trace.push_back(mk(rnd(), W_RW | W_M2R | W_PC4));
      end
      O_ST: begin
        trace.push_back(mk(rnd(), W_A | W_BIMM));
        for (int i = 0; i < mw; i++) trace.push_back(mk(1'b0, W_MW | W_IOD));
        trace.push_back(mk(1'b1, W_MW | W_IOD | W_PC4));
      end
      O_BR: begin
        if (bc) begin
          trace.push_back(mk(rnd(), W_A | W_OPBR));
          trace.push_back(mk(rnd(), W_BIMM | W_PCW));
        end else begin
          trace.push_back(mk(rnd(), W_A | W_OPBR | W_PCW | W_PS));
        end
      end
      O_JL: trace.push_back(mk(rnd(), W_RW | W_BIMM | W_PCW));
      O_JR: trace.push_back(mk(rnd(), W_RW | W_BIMM | W_PCW | W_A));
      O_EC: begin
        if (hc) begin
          trace.push_back(mk(rnd(), 14'h0000));
          halts = 1'b1;
        end else begin
          trace.push_back(mk(rnd(), W_PC4));
        end
      end
      default: begin
        retires = 1'b0;
        halts   = 1'b1;
      end
    endcase
  endtask

  // Entry/exit point: #1 after a rising edge.
  task automatic run_instr(input logic [6:0] op, input logic bc, input logic hc,
                           input int fw, input int mw, output logic halts);
    logic retires;
    build_trace(op, bc, hc, fw, mw, retires, halts);
    opcode = op; bcond = bc; halt_cond = hc;
    foreach (trace[i]) begin
      reset     = 1'b1;
      mem_ready = trace[i].mr;
      @(negedge clk);
      chk("trace", 32'(act_w), 32'(trace[i].w));
      chk("trace_s", 32'(act_s), 32'(trace[i].w));
      if (mem_read && i_or_d) obs_memd++;
      if (mem_to_reg && reg_write) obs_m2r++;
      @(posedge clk); #1;
    end
    if (retires) model_cnt = model_cnt + 32'd1;
    chk("count", instr_count, model_cnt);
    chk("count_s", 32'(instr_count_s), 32'(3'(model_cnt)));
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1'b1; mem_ready = rnd(); bcond = rnd(); halt_cond = rnd(); opcode = 7'($urandom);
      @(negedge clk);
      chk("halted", 32'(act_w), 32'(W_H));
      @(posedge clk); #1;
    end
    chk("halt_count", instr_count, model_cnt);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1'b0; mem_ready = rnd(); bcond = rnd(); halt_cond = rnd(); opcode = 7'($urandom);
      @(negedge clk);
      chk("rst_out", 32'(act_w), 32'd0);
      @(posedge clk); #1;
    end
    model_cnt = 32'd0;
    chk("rst_count", instr_count, 32'd0);
    chk("rst_count_s", 32'(instr_count_s), 32'd0);
  endtask

  // Zero-wait cycle count: cycles until the next fetch (ir_write) or until halted.
  task automatic measure(input int row, input vec_t v);
    int   n;
    logic done;
    opcode = v.op; bcond = v.bc; halt_cond = v.hc; reset = 1'b1; mem_ready = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (n > 0 && (ir_write || halted)) done = 1'b1;
      else begin
        n++;
        @(posedge clk); #1;
      end
    end
    chk($sformatf("cpi_row%0d", row), 32'(n), 32'(v.cyc));
    chk($sformatf("retire_row%0d", row), instr_count, 32'(v.delta));
    @(posedge clk); #1;
    do_reset(1);
  endtask

  vec_t       tbl[12];
  logic [6:0] ops[9];
  logic       h;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{O_R,  1'b0, 1'b0, 8'd4, 8'd1};
    tbl[1]  = '{O_I,  1'b0, 1'b0, 8'd4, 8'd1};
    tbl[2]  = '{O_LD, 1'b0, 1'b0, 8'd5, 8'd1};
    tbl[3]  = '{O_ST, 1'b0, 1'b0, 8'd4, 8'd1};
    tbl[4]  = '{O_BR, 1'b0, 1'b0, 8'd3, 8'd1};
    tbl[5]  = '{O_BR, 1'b1, 1'b0, 8'd4, 8'd1};
    tbl[6]  = '{O_JL, 1'b0, 1'b0, 8'd3, 8'd1};
    tbl[7]  = '{O_JR, 1'b0, 1'b0, 8'd3, 8'd1};
    tbl[8]  = '{O_EC, 1'b0, 1'b0, 8'd3, 8'd1};
    tbl[9]  = '{O_EC, 1'b0, 1'b1, 8'd3, 8'd1};
    tbl[10] = '{7'b0000000, 1'b0, 1'b0, 8'd2, 8'd0};
    tbl[11] = '{7'b0110111, 1'b1, 1'b1, 8'd2, 8'd0};
    ops = '{O_R, O_I, O_LD, O_ST, O_BR, O_JL, O_JR, O_EC, 7'b0000000};
    obs_memd = 0; obs_m2r = 0; model_cnt = 32'd0;

    reset = 1'b0; opcode = 7'd0; bcond = 1'b0; halt_cond = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(2);

    foreach (tbl[i]) measure(i, tbl[i]);

    // R-type add, zero wait.
    run_instr(O_R, 1'b0, 1'b0, 0, 0, h);
    // Load with two wait cycles in MEM_LD.
    obs_memd = 0; obs_m2r = 0;
    run_instr(O_LD, 1'b0, 1'b0, 0, 2, h);
    chk("ld_mem_cycles", 32'(obs_memd), 32'd3);
    chk("ld_m2r_cycles", 32'(obs_m2r), 32'd1);
    // Branch not taken then taken.
    run_instr(O_BR, 1'b0, 1'b0, 0, 0, h);
    run_instr(O_BR, 1'b1, 1'b0, 1, 0, h);
    // ECALL continue, then ECALL halt held 100 cycles.
    run_instr(O_EC, 1'b0, 1'b0, 0, 0, h);
    run_instr(O_EC, 1'b0, 1'b1, 0, 0, h);
    hold_halt(100);
    do_reset(1);

    // Reset during a store wait aborts it.
    run_instr(O_R, 1'b0, 1'b0, 0, 0, h);
    opcode = O_ST; bcond = 1'b0; halt_cond = 1'b0;
    for (int i = 0; i < 4; i++) begin
      reset = 1'b1; mem_ready = (i == 0) ? 1'b1 : (i == 3) ? 1'b0 : rnd();
      @(negedge clk);
      if (i == 3) chk("st_wait_strobe", 32'(mem_write), 32'd1);
      @(posedge clk); #1;
    end
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("st_rst_out", 32'(act_w), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    chk("st_rst_if", 32'(act_w), 32'(W_MR));
    chk("st_rst_count", instr_count, 32'd0);
    @(posedge clk); #1;
    do_reset(1);

    // Counter wrap on the narrow twin.
    for (int i = 0; i < 8; i++) run_instr(O_JL, 1'b0, 1'b0, 0, 0, h);
    chk("wrap_s", 32'(instr_count_s), 32'd0);
    chk("wrap_wide", instr_count, 32'd8);

    // Randomized instruction stream.
    for (int k = 0; k < 150; k++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      run_instr(op, rnd(), ($urandom_range(0, 7) == 0), $urandom_range(0, 2),
                $urandom_range(0, 2), h);
      if (h) begin
        hold_halt($urandom_range(2, 6));
        do_reset($urandom_range(1, 2));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
